// File: rtl/col2im_acc_if.sv
// Column-in / map-out bundle for col2im_acc: column handshake, abort, and finished-map handshake.
// Latency: none, signal bundle only.
// Backpressure: in_ready throttles columns; out_ready releases the finished map.
interface col2im_acc_if #(
   parameter int CH = 32,
   parameter int DW = 16,
   parameter int AW = DW + 4
);
   logic                   clr;
   logic                   in_valid;
   logic                   in_ready;
   logic [9*CH*DW-1:0]     in_col;
   logic [3:0]             col_idx;
   logic                   out_valid;
   logic                   out_ready;
   logic [CH*30*AW-1:0]    q;

   modport master (
      output clr, in_valid, in_col, out_ready,
      input  in_ready, col_idx, out_valid, q
   );

   modport slave (
      input  clr, in_valid, in_col, out_ready,
      output in_ready, col_idx, out_valid, q
   );
endinterface

// File: rtl/col2im_acc.sv
// Overlap-adds twelve 3x3xCH columns (stride 1) into a (CH,5,6) map; adjoint of im2col.
// Latency: out_valid rises the cycle after the 12th accepted column; q is the live accumulator.
// Backpressure: in_ready drops while a finished map waits; the map is held until out_ready.
module col2im_acc #(
   parameter int CH = 32,
   parameter int DW = 16,
   parameter int AW = DW + 4
) (
   input  logic        clk,
   input  logic        rst,
   col2im_acc_if.slave bus
);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] col_cnt;
   logic [3:0] col_cnt_next;
   logic       accept;
   logic       zero_acc;
   logic [1:0] j;
   logic [1:0] k;

   // Column n lands with its top-left tap at map row n/4, column n%4.
   assign j = col_cnt[3:2];
   assign k = col_cnt[1:0];

   // Handshake outputs are pure state decodes so no input reaches them combinationally.
   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   assign bus.col_idx   = col_cnt;

   function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
      return {{(AW-DW){v[DW-1]}}, v};
   endfunction

   // State and column counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACCUM;
         col_cnt <= '0;
      end else begin
         state   <= state_next;
         col_cnt <= col_cnt_next;
      end
   end

   // Next state: abort wins over both accept and drain; DONE ignores in_valid.
   always_comb begin
      state_next   = state;
      col_cnt_next = col_cnt;
      accept       = 1'b0;
      zero_acc     = 1'b0;
      if (bus.clr) begin
         state_next   = ACCUM;
         col_cnt_next = '0;
         zero_acc     = 1'b1;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  accept = 1'b1;
                  if (col_cnt == 4'd11) begin
                     state_next   = DONE;
                     col_cnt_next = '0;
                  end else begin
                     col_cnt_next = col_cnt + 4'd1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_next = ACCUM;
                  zero_acc   = 1'b1;
               end
            end
            default: state_next = ACCUM;
         endcase
      end
   end

   // One accumulator per map element; each element sees at most one tap of the current column.
   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      for (genvar gy = 0; gy < 5; gy++) begin : g_row
         for (genvar gx = 0; gx < 6; gx++) begin : g_col
            logic [AW-1:0] acc;
            logic [AW-1:0] add;

            // Select the kernel tap (r,c) with j+r==gy and k+c==gx, or zero if none lands here.
            always_comb begin
               add = '0;
               for (int r = 0; r < 3; r++) begin
                  for (int c = 0; c < 3; c++) begin
                     if ((int'(j) + r == gy) && (int'(k) + c == gx)) begin
                        add = sext(bus.in_col[(9*gi + 3*r + c)*DW +: DW]);
                     end
                  end
               end
            end

            // Signed wrap-free accumulate on accept; cleared on abort or when the map is taken.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  acc <= '0;
               end else if (zero_acc) begin
                  acc <= '0;
               end else if (accept) begin
                  acc <= acc + add;
               end
            end

            assign bus.q[(30*gi + 6*gy + gx)*AW +: AW] = acc;
         end
      end
   end

endmodule

// File: tb/tb_col2im_acc.sv
// Directed scoreboard bench for col2im_acc: expected maps queued at stimulus time, checked on out handshake.
// Latency: checks out_valid exactly one cycle after the 12th accept.
// Backpressure: holds out_ready low with in_valid high and checks the map stays put.
module tb_col2im_acc;
   localparam int CH = 32;
   localparam int DW = 16;
   localparam int AW = 20;
   localparam int CW = 9*CH*DW;
   localparam int QW = CH*30*AW;

   localparam int RY [5] = '{1, 2, 3, 2, 1};
   localparam int CX [6] = '{1, 2, 3, 3, 2, 1};

   localparam logic [DW-1:0] M7_DW = 16'hFFF9;
   localparam logic [AW-1:0] M7_AW = 20'hFFFF9;
   localparam logic [DW-1:0] MAXV  = 16'h7FFF;
   localparam logic [DW-1:0] MINV  = 16'h8000;

   typedef logic [CW-1:0] col_t;
   typedef logic [QW-1:0] map_t;

   logic clk;
   logic rst;

   col2im_acc_if #(.CH(CH), .DW(DW), .AW(AW)) bus ();

   col2im_acc #(.CH(CH), .DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   col_t cols [12];
   map_t exp_q [$];
   map_t imp_map;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_map(input string name, input map_t act, input map_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int e = 0; e < CH*30; e++) begin
            if (act[e*AW +: AW] !== exp[e*AW +: AW]) begin
               $display("FAIL %s: element %0d (ch %0d y %0d x %0d) got %0h expected %0h",
                        name, e, e/30, (e%30)/6, e%6, act[e*AW +: AW], exp[e*AW +: AW]);
               break;
            end
         end
      end
   endtask

   function automatic logic [AW-1:0] qel(input int i, input int y, input int x);
      return bus.q[(30*i + 6*y + x)*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
      return {{(AW-DW){v[DW-1]}}, v};
   endfunction

   // Hand-derived closed form for the all-ones case: row coverage times column coverage.
   function automatic map_t ones_map();
      map_t m = '0;
      for (int i = 0; i < CH; i++)
         for (int y = 0; y < 5; y++)
            for (int x = 0; x < 6; x++)
               m[(30*i + 6*y + x)*AW +: AW] = AW'(RY[y] * CX[x]);
      return m;
   endfunction

   // Reference overlap-add over the twelve stored columns.
   function automatic map_t model_map();
      map_t m = '0;
      for (int n = 0; n < 12; n++)
         for (int i = 0; i < CH; i++)
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++) begin
                  int e = 30*i + 6*(n/4 + r) + (n%4 + c);
                  m[e*AW +: AW] = m[e*AW +: AW] + sext(cols[n][(9*i + 3*r + c)*DW +: DW]);
               end
      return m;
   endfunction

   // mode 0: zeros, 1: all ones, 2: random max/min per element
   task automatic fill_cols(input int mode);
      for (int n = 0; n < 12; n++)
         for (int e = 0; e < 9*CH; e++)
            case (mode)
               0:       cols[n][e*DW +: DW] = '0;
               1:       cols[n][e*DW +: DW] = 16'd1;
               default: cols[n][e*DW +: DW] = ($urandom_range(1, 0) == 1) ? MAXV : MINV;
            endcase
   endtask

   // Send ncols columns with 0..max_gap idle cycles before each; ends at posedge+1 after the last accept.
   task automatic run_cols(input int max_gap, input int ncols);
      for (int n = 0; n < ncols; n++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         bus.in_valid = 1'b0;
         repeat (gap) tick();
         check("col_idx_before_accept", bus.col_idx, n);
         check("in_ready_accum", bus.in_ready, 1);
         bus.in_valid = 1'b1;
         bus.in_col   = cols[n];
         tick();
         bus.in_valid = 1'b0;
         check("out_valid_after_accept", bus.out_valid, (n == 11) ? 1 : 0);
      end
   endtask

   task automatic ones_spots();
      for (int i = 0; i < CH; i += CH-1) begin
         check("ones_q_2_2", qel(i, 2, 2), 9);
         check("ones_q_0_0", qel(i, 0, 0), 1);
         check("ones_q_4_5", qel(i, 4, 5), 1);
         check("ones_q_1_3", qel(i, 1, 3), 6);
      end
   endtask

   task automatic drain_and_check();
      tick();
      check_map("q_after_drain", bus.q, '0);
      check("in_ready_after_drain", bus.in_ready, 1);
      check("out_valid_after_drain", bus.out_valid, 0);
   endtask

   // Scoreboard monitor: compares q against the oldest expectation on each output handshake.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: out_valid=1 with empty queue, expected no output");
         end else begin
            map_t e;
            e = exp_q.pop_front();
            check_map("scoreboard_q", bus.q, e);
         end
      end
   end

   initial begin
      col_t junk;
      junk = '1;
      rst           = 1'b1;
      bus.clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_col    = '0;
      bus.out_ready = 1'b1;
      repeat (2) tick();

      // reset state, held while rst is high
      check_map("reset_q", bus.q, '0);
      check("reset_col_idx", bus.col_idx, 0);
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      tick();

      // reset pulse while column 6 is presented
      fill_cols(1);
      run_cols(0, 6);
      bus.in_valid = 1'b1;
      bus.in_col   = cols[6];
      #2 rst = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      rst = 1'b0;
      check_map("midrst_q", bus.q, '0);
      check("midrst_col_idx", bus.col_idx, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      tick();

      // full all-ones run after the reset
      exp_q.push_back(ones_map());
      run_cols(0, 12);
      ones_spots();
      drain_and_check();

      // single negative impulse, then held under backpressure
      fill_cols(0);
      cols[5][29*DW +: DW] = M7_DW;
      imp_map = '0;
      imp_map[(30*3 + 6*1 + 3)*AW +: AW] = M7_AW;
      exp_q.push_back(imp_map);
      bus.out_ready = 1'b0;
      run_cols(1, 12);
      check("impulse_q_3_1_3", qel(3, 1, 3), M7_AW);
      check("impulse_q_3_1_2", qel(3, 1, 2), 0);
      for (int t = 0; t < 10; t++) begin
         bus.in_valid = 1'b1;
         bus.in_col   = junk;
         tick();
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_col_idx", bus.col_idx, 0);
         check_map("bp_q_held", bus.q, imp_map);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain_and_check();

      // abort after five accepts with a column offered in the same cycle
      fill_cols(1);
      run_cols(0, 5);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_col   = cols[5];
      tick();
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_col_idx", bus.col_idx, 0);
      check_map("abort_q", bus.q, '0);
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      exp_q.push_back(ones_map());
      run_cols(2, 12);
      ones_spots();
      drain_and_check();

      // gapped random max/min columns against the reference model
      for (int run = 0; run < 2; run++) begin
         fill_cols(2);
         exp_q.push_back(model_map());
         run_cols(3, 12);
         drain_and_check();
      end

      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/col2im_acc.md
COL2IM_ACC -- requirements
Module: col2im_acc

Interface
REQ-001 Parameter CH, default 32: number of channels.
REQ-002 Parameter DW, default 16: width of one signed two's-complement input element.
REQ-003 Parameter AW, default DW+4: width of one signed accumulator or output element.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 clr  input  1: synchronous abort; clears accumulators and column counter.
REQ-007 in_valid  input  1: in_col carries a valid column.
REQ-008 in_ready  output  1: block accepts a column this cycle.
REQ-009 in_col  input  9*CH*DW: one 3x3xCH column; element (ch i, kernel row r, kernel col c) at index 9*i+3*r+c, bits [idx*DW +: DW].
REQ-010 col_idx  output  4: index n (0..11) of the next column to be accepted.
REQ-011 out_valid  output  1: q holds a complete (CH,5,6) map.
REQ-012 out_ready  input  1: consumer takes q.
REQ-013 q  output  CH*30*AW: map element (ch i, row y 0..4, col x 0..5) at index 30*i+6*y+x, bits [idx*AW +: AW].

Function
REQ-014 Block SHALL be the adjoint of the 3x3, stride-1 im2col on a (CH,5,6) map: overlap-add of 12 columns into a (CH,5,6) map.
REQ-015 Column n SHALL map to output position j=n/4 (0..2), k=n%4 (0..3), with columns arriving in order n=0..11.
REQ-016 On accept (in_valid && in_ready), for all i,r,c: acc[i][j+r][k+c] += sign-extend(in_col element (i,r,c)); all 9*CH adds in one cycle.
REQ-017 Accumulation SHALL be signed, sign-extended to AW, no saturation; AW>=DW+4 guarantees no overflow (max coverage 9).
REQ-018 q SHALL be the accumulator registers driven directly; q changes only on accept, drain, clr, or reset.
REQ-019 FSM states: ACCUM, DONE.
REQ-020 ACCUM: in_ready=1, out_valid=0; each accept increments col_idx; accept at col_idx=11 -> DONE and col_idx=0 at the same edge.
REQ-021 DONE: in_ready=0, out_valid=1, q stable; in_valid ignored.
REQ-022 DONE && out_ready -> all accumulators zeroed, state ACCUM; in_ready=1 from the following cycle.
REQ-023 Latency: out_valid SHALL rise on the cycle after the 12th accept.
REQ-024 out_valid SHALL stay high indefinitely while out_ready=0.
REQ-025 in_valid gaps SHALL be allowed; idle cycles leave state, col_idx, and q unchanged.
REQ-026 clr=1 in any state: next edge accumulators=0, col_idx=0, state ACCUM; clr has priority over accept and drain in the same cycle.
REQ-027 in_ready and out_valid SHALL be registered-state decodes, with no combinational path from in_valid or out_ready.

Reset
REQ-028 On rst: state ACCUM, col_idx=0, all q elements 0, out_valid=0, in_ready=1, held while rst=1.
REQ-029 rst asserted mid-sequence SHALL discard partial accumulation; the first accept after release is column 0.

Verification
REQ-030 Reset: rst pulse during column 6 -> q all 0, col_idx=0, in_ready=1, out_valid=0; a following 12-column sequence gives the correct result.
REQ-031 All-ones: 12 columns with every element =1 -> q(i,y,x)=Ry[y]*Cx[x], Ry={1,2,3,2,1}, Cx={1,2,3,3,2,1}; e.g. (i,2,2)=9, (i,0,0)=1, (i,4,5)=1, (i,1,3)=6, for all i.
REQ-032 Single impulse: only column n=5, ch 3, r=0, c=2 = -7 (others 0) -> q(3,1,3)=-7 (AW-bit 0x...FF9), every other element 0.
REQ-033 Backpressure: after the 12th accept, out_ready=0 and in_valid=1 for 10 cycles -> out_valid=1, in_ready=0, q unchanged; then out_ready=1 one cycle -> next cycle q=0, in_ready=1.
REQ-034 Abort: clr after 5 accepts, with in_valid=1 in the same cycle -> column not taken, col_idx=0, q=0; a fresh 12-column all-ones run reproduces REQ-031.
REQ-035 Gapped input: random 0-3 idle cycles between columns, random signed max/min values -> q matches a reference overlap-add model bit-exact, with out_valid exactly one cycle after the 12th accept.
